nn_img_loader: RTL and testbench
================================

// Module: nn_img_loader
// PURPOSE
//  Upstream feeder for the image buffer. Accepts a serial 8-bit pixel stream
//  over a valid/ready handshake and packs 6 pixels into one 48-bit word. Writes
//  each word into the image buffer write port at consecutive addresses from a
//  programmable base. The sequence repeats once per start command.
// PARAMETERS
//  DATA_WIDTH        8                  bits per pixel
//  ADDR_WIDTH        12                 image buffer address width
//  PACK              6                  pixels per buffer word
//  TOTAL_DATA_WIDTH  DATA_WIDTH*PACK    buffer word width
// PORTS
//  i_clk        in   1                  clock; all state updates on rising edge
//  i_rst        in   1                  asynchronous, active-high reset
//  i_start      in   1                  1-cycle load command; sampled only in IDLE
//  i_base_addr  in   ADDR_WIDTH         first buffer word address; latched on start
//  i_num_px     in   ADDR_WIDTH+3       pixel count for this load; latched on start
//  i_px_valid   in   1                  pixel stream valid
//  i_px_data    in   DATA_WIDTH         pixel value
//  o_px_ready   out  1                  loader accepts a pixel this cycle
//  o_wr_en      out  1                  buffer write strobe (drives i_wr_en)
//  o_wr_addr    out  ADDR_WIDTH         buffer write address
//  o_wr_data    out  TOTAL_DATA_WIDTH   packed word; lane 0 = bits [7:0]
//  o_busy       out  1                  high whenever state != IDLE
//  o_done       out  1                  1-cycle pulse: load finished
// BEHAVIOUR
//  Reset: state=IDLE; o_px_ready, o_wr_en, o_busy, o_done = 0.
//   o_wr_addr = 0; o_wr_data = 0; lane index = 0; pixel count = 0.
//  Accept: a pixel transfers when i_px_valid && o_px_ready.
//  FSM: IDLE -> LOAD -> DONE -> IDLE.
//  IDLE: o_px_ready=0.
//   - i_start && i_num_px!=0: latch base and count, go to LOAD.
//   - i_start && i_num_px==0: o_done=1 next cycle, stay IDLE, no write.
//  LOAD: o_px_ready=1 (combinational from state).
//   - Accepted pixel goes to the current lane, in lanes 0..PACK-1 order.
//   - Lane counter increments; wraps to 0 after lane PACK-1.
//  Word emit, registered: occurs the cycle after accepting the lane-5 pixel
//   or the final pixel.
//   - o_wr_en=1 for exactly 1 cycle, with o_wr_data and o_wr_addr valid.
//   - Unfilled lanes of a final partial word are 0.
//   - Word address = base + word index, modulo 2^ADDR_WIDTH (wraps 4095->0).
//  Final pixel accepted (count reaches i_num_px): LOAD->DONE, o_px_ready drops
//   next cycle.
//  DONE: lasts 1 cycle. o_done=1 and the final o_wr_en=1 in the same cycle.
//   Next state IDLE. o_busy=1 during DONE.
//  Throughput: 1 pixel/cycle; at most one write every PACK cycles.
//   The buffer write has priority, so no write backpressure exists.
//  i_start while busy: ignored. Latched parameters do not change mid-load.
//  i_px_valid in IDLE/DONE: ignored; no pixel is consumed.
//  Input stall (i_px_valid=0): holds lane/count; the partial word stays held.
//  Reset mid-load: immediate return to IDLE.
//   - Partial word discarded; no write, no o_done.
//   - Words already written stay in the buffer.
// TESTING
//  1. base=0, num_px=12, pixels 1..12 back-to-back ->
//     writes @0=0x060504030201, @1=0x0C0B0A090807; o_done with 2nd write.
//  2. base=10, num_px=8, pixels 0xA0.. ->
//     @10=0xA5A4A3A2A1A0, @11=0x0000_0000A7A6 (lanes 2-5 zero); 1 o_done.
//  3. base=4095, num_px=12 -> writes at 4095 then 0 (address wrap).
//  4. Random valid gaps (about 50% duty), num_px=30 -> 5 writes, same data as
//     gap-free; o_px_ready=0 after the last accept.
//  5. num_px=0 start -> o_done one cycle later, o_wr_en never asserted.
//     Start pulse during LOAD -> ignored.
//  6. Assert i_rst after 9 of 12 pixels -> only @base written.
//     o_busy=0, o_done=0; a new load then runs cleanly from lane 0.

Source files
------------

// File: rtl/nn_img_loader_if.sv
// Bundle for nn_img_loader: start command, pixel stream and buffer write port.
// slave = the loader itself, master = whoever drives the stream and owns the buffer.
interface nn_img_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int PACK       = 6
);
    localparam int TW = DATA_WIDTH * PACK;

    logic                  i_start;
    logic [ADDR_WIDTH-1:0] i_base_addr;
    logic [ADDR_WIDTH+2:0] i_num_px;
    logic                  i_px_valid;
    logic [DATA_WIDTH-1:0] i_px_data;
    logic                  o_px_ready;
    logic                  o_wr_en;
    logic [ADDR_WIDTH-1:0] o_wr_addr;
    logic [TW-1:0]         o_wr_data;
    logic                  o_busy;
    logic                  o_done;

    modport slave (
        input  i_start, i_base_addr, i_num_px, i_px_valid, i_px_data,
        output o_px_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done
    );

    modport master (
        output i_start, i_base_addr, i_num_px, i_px_valid, i_px_data,
        input  o_px_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done
    );
endinterface

// File: rtl/nn_img_loader.sv
// Image buffer feeder: packs PACK serial pixels per word and writes them
// to consecutive buffer addresses starting at a latched base.
module nn_img_loader #(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDR_WIDTH       = 12,
    parameter int PACK             = 6,
    parameter int TOTAL_DATA_WIDTH = DATA_WIDTH * PACK
) (
    input  logic           i_clk,
    input  logic           i_rst,
    nn_img_loader_if.slave bus
);
    localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int CW = ADDR_WIDTH + 3;
    localparam logic [LW-1:0] LAST_LANE = LW'(PACK - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_e;

    state_e                      state_q;
    logic [LW-1:0]               lane_q;
    logic [CW-1:0]               cnt_q;
    logic [CW-1:0]               num_q;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [ADDR_WIDTH-1:0]       wr_addr_q;
    logic [TOTAL_DATA_WIDTH-1:0] word_q;
    logic [TOTAL_DATA_WIDTH-1:0] word_d;
    logic [TOTAL_DATA_WIDTH-1:0] wr_data_q;
    logic                        wr_en_q;
    logic                        done_q;
    logic [CW-1:0]               cnt_d;
    logic                        accept;
    logic                        last_px;
    logic                        word_full;

    assign bus.o_px_ready = (state_q == LOAD);
    assign bus.o_busy     = (state_q != IDLE);
    assign bus.o_wr_en    = wr_en_q;
    assign bus.o_wr_addr  = wr_addr_q;
    assign bus.o_wr_data  = wr_data_q;
    assign bus.o_done     = done_q;

    assign accept    = bus.i_px_valid && (state_q == LOAD);
    assign cnt_d     = cnt_q + 1'b1;
    assign last_px   = (cnt_d == num_q);
    assign word_full = (lane_q == LAST_LANE);

    // Current partial word with the incoming pixel dropped into its lane.
    always_comb begin
        word_d = word_q;
        word_d[lane_q*DATA_WIDTH +: DATA_WIDTH] = bus.i_px_data;
    end

    // Load sequencer; the write strobe and done pulse are registered here.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            lane_q    <= '0;
            cnt_q     <= '0;
            num_q     <= '0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            word_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        if (bus.i_num_px != '0) begin
                            state_q <= LOAD;
                            num_q   <= bus.i_num_px;
                            addr_q  <= bus.i_base_addr;
                            lane_q  <= '0;
                            cnt_q   <= '0;
                            word_q  <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        cnt_q <= cnt_d;
                        if (word_full || last_px) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_q;
                            wr_data_q <= word_d;
                            addr_q    <= addr_q + 1'b1;
                            word_q    <= '0;
                            lane_q    <= '0;
                        end else begin
                            word_q <= word_d;
                            lane_q <= lane_q + 1'b1;
                        end
                        if (last_px) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nn_img_loader.sv
// Self-checking bench for nn_img_loader.
// Expected buffer writes are queued when a load is issued and popped on o_wr_en.
module tb_nn_img_loader;
    logic clk;
    logic rst;

    nn_img_loader_if bus ();

    nn_img_loader dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    bit exp_wr_with_done = 1'b1;
    logic [59:0] sb_q[$];
    logic [59:0] e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_wr_en) begin
                wr_cnt++;
                if (sb_q.size() == 0) begin
                    chk("unexp_wr", 64'(bus.o_wr_addr), 64'hFFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("wr_addr", 64'(bus.o_wr_addr), 64'(e[59:48]));
                    chk("wr_data", 64'(bus.o_wr_data), 64'(e[47:0]));
                end
            end
            if (bus.o_done) begin
                done_cnt++;
                chk("done_w_wr", 64'(bus.o_wr_en), 64'(exp_wr_with_done));
            end
        end
    end

    task automatic push_exp(input logic [11:0] base, input int num,
                            input logic [7:0] p0);
        logic [47:0] w;
        int nw;
        nw = (num + 5) / 6;
        for (int k = 0; k < nw; k++) begin
            w = '0;
            for (int j = 0; j < 6; j++)
                if (k * 6 + j < num) w[j*8 +: 8] = p0 + 8'(k * 6 + j);
            sb_q.push_back({base + 12'(k), w});
        end
    endtask

    task automatic start_cmd(input logic [11:0] base, input int num);
        @(posedge clk); #1;
        bus.i_start     = 1'b1;
        bus.i_base_addr = base;
        bus.i_num_px    = 15'(num);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    task automatic stream(input int num, input logic [7:0] p0,
                          input bit gaps, input bit poke);
        int sent;
        int budget;
        bit acc;
        bit poked;
        sent = 0;
        budget = 0;
        poked = 1'b0;
        while (sent < num && budget < 1000) begin
            bus.i_px_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.i_px_data  = p0 + 8'(sent);
            if (poke && !poked && sent == 3) begin
                bus.i_start     = 1'b1;
                bus.i_base_addr = 12'd777;
                bus.i_num_px    = 15'd1;
                poked = 1'b1;
            end
            acc = bus.i_px_valid && bus.o_px_ready;
            @(posedge clk); #1;
            bus.i_start = 1'b0;
            if (acc) sent++;
            budget++;
        end
        bus.i_px_valid = 1'b0;
        if (sent != num) chk("px_timeout", 64'(sent), 64'(num));
    endtask

    task automatic run_load(input logic [11:0] base, input int num,
                            input logic [7:0] p0, input bit gaps,
                            input bit poke);
        int d0;
        int t;
        d0 = done_cnt;
        exp_wr_with_done = 1'b1;
        push_exp(base, num, p0);
        start_cmd(base, num);
        stream(num, p0, gaps, poke);
        chk("ready_drop", 64'(bus.o_px_ready), 64'd0);
        chk("busy_done", 64'(bus.o_busy), 64'd1);
        t = 0;
        while (done_cnt == d0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        chk("busy_idle", 64'(bus.o_busy), 64'd0);
    endtask

    initial begin
        int w0;
        int d0;
        rst             = 1'b1;
        bus.i_start     = 1'b0;
        bus.i_base_addr = '0;
        bus.i_num_px    = '0;
        bus.i_px_valid  = 1'b0;
        bus.i_px_data   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(bus.o_px_ready), 64'd0);
        chk("rst_wr_en", 64'(bus.o_wr_en), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_done", 64'(bus.o_done), 64'd0);
        chk("rst_addr", 64'(bus.o_wr_addr), 64'd0);
        chk("rst_data", 64'(bus.o_wr_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_load(12'd0, 12, 8'h01, 1'b0, 1'b0);
        run_load(12'd10, 8, 8'hA0, 1'b0, 1'b0);
        run_load(12'd4095, 12, 8'h40, 1'b0, 1'b0);
        run_load(12'd50, 30, 8'h10, 1'b1, 1'b1);

        // Zero-length load: done one cycle later, no write.
        w0 = wr_cnt;
        d0 = done_cnt;
        exp_wr_with_done = 1'b0;
        start_cmd(12'd5, 0);
        chk("zero_done", 64'(bus.o_done), 64'd1);
        chk("zero_busy", 64'(bus.o_busy), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("zero_nowr", 64'(wr_cnt - w0), 64'd0);
        chk("zero_dcnt", 64'(done_cnt - d0), 64'd1);

        // Reset after 9 of 12 pixels: only the first word lands.
        w0 = wr_cnt;
        d0 = done_cnt;
        exp_wr_with_done = 1'b1;
        push_exp(12'd200, 6, 8'h50);
        start_cmd(12'd200, 12);
        stream(9, 8'h50, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        chk("mrst_busy", 64'(bus.o_busy), 64'd0);
        chk("mrst_done", 64'(bus.o_done), 64'd0);
        chk("mrst_ready", 64'(bus.o_px_ready), 64'd0);
        chk("mrst_wr_en", 64'(bus.o_wr_en), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_sb", 64'(sb_q.size()), 64'd0);
        chk("mrst_nwr", 64'(wr_cnt - w0), 64'd1);
        chk("mrst_ndone", 64'(done_cnt - d0), 64'd0);
        run_load(12'd300, 6, 8'h30, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
